// File: rtl/sb_pkg.sv
// Shared constants and helper functions for the parametrised switch box.
package sb_pkg;

    localparam int SB_SIDES      = 4;
    localparam int SB_CFG_WORD_W = 32;

    // Select field width: enough codes for 3 side sources plus every PE output.
    function automatic int sb_sel_w(input int num_pe);
        return $clog2(3 + num_pe);
    endfunction

    // Number of 32-bit configuration words holding one (sel, reg_en) field per output.
    function automatic int sb_cfg_words(input int tracks, input int num_pe);
        int f;
        f = sb_sel_w(num_pe) + 1;
        return (SB_SIDES * tracks * f + SB_CFG_WORD_W - 1) / SB_CFG_WORD_W;
    endfunction

    // Side feeding mux input k of an output on side s.
    function automatic int sb_src_side(input int s, input int k);
        return (s + 1 + k) % SB_SIDES;
    endfunction

    // Track feeding mux input k of output (s, t).
    function automatic int sb_src_track(input int t, input int s, input int k, input int tracks);
        return (t + s + k) % tracks;
    endfunction

endpackage

// File: rtl/sb_track_mux.sv
// One switch-box output: NSRC-way select mux (zero for unused codes), a capture
// flop that clocks every cycle, and a reg_en bypass choosing flop or mux.
module sb_track_mux #(
    parameter int WIDTH = 1,
    parameter int NSRC  = 4,
    parameter int SEL_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NSRC*WIDTH-1:0]   srcs,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    reg_en,
    output logic [WIDTH-1:0]        out
);

    logic [WIDTH-1:0] pipe_d;
    logic [WIDTH-1:0] pipe_q;

    // Source select; codes at or above NSRC drive zero.
    always_comb begin
        pipe_d = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SEL_W'(k)) begin
                pipe_d = srcs[k*WIDTH +: WIDTH];
            end
        end
    end

    // Capture flop runs regardless of reg_en so toggling reg_en adds no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign out = reg_en ? pipe_q : pipe_d;

endmodule

// File: rtl/switch_box_param.sv
// Parametrised routing switch box with a double-buffered configuration bank.
// Optional feature macro: SB_CFG_READBACK_EN adds a registered shadow-bank read port.
module switch_box_param
    import sb_pkg::*;
#(
    parameter int  WIDTH     = 1,
    parameter int  TRACKS    = 4,
    parameter int  NUM_PE    = 1,
    localparam int NSRC      = 3 + NUM_PE,
    localparam int SEL_W     = sb_sel_w(NUM_PE),
    localparam int F         = SEL_W + 1,
    localparam int CFG_WORDS = sb_cfg_words(TRACKS, NUM_PE),
    localparam int ADDR_W    = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [SB_SIDES*TRACKS*WIDTH-1:0] in_wires,
    input  logic [NUM_PE*WIDTH-1:0]         pe_outputs,
    input  logic                            config_en,
    input  logic [ADDR_W-1:0]               config_addr,
    input  logic [SB_CFG_WORD_W-1:0]        config_data,
    input  logic                            config_commit,
`ifdef SB_CFG_READBACK_EN
    input  logic [ADDR_W-1:0]               config_rd_addr,
    output logic [SB_CFG_WORD_W-1:0]        config_rd_data,
`endif
    output logic [SB_SIDES*TRACKS*WIDTH-1:0] out_wires
);

    // Only the bits that hold fields are stored; padding bits always read as 0.
    localparam int CFG_BITS = SB_SIDES * TRACKS * F;

    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;

    // Shadow writes and commit; a same-cycle commit copies the pre-write shadow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (config_commit) begin
                active <= shadow;
            end
            if (config_en) begin
                for (int b = 0; b < CFG_BITS; b++) begin
                    if (config_addr == ADDR_W'(b / SB_CFG_WORD_W)) begin
                        shadow[b] <= config_data[b % SB_CFG_WORD_W];
                    end
                end
            end
        end
    end

`ifdef SB_CFG_READBACK_EN
    localparam int PAD_W = CFG_WORDS * SB_CFG_WORD_W;

    logic [PAD_W-1:0]         shadow_pad;
    logic [SB_CFG_WORD_W-1:0] rd_d;
    logic [SB_CFG_WORD_W-1:0] rd_q;

    assign shadow_pad = PAD_W'(shadow);

    // Readback word select; out-of-range addresses match no word and return 0.
    always_comb begin
        rd_d = '0;
        for (int w = 0; w < CFG_WORDS; w++) begin
            if (config_rd_addr == ADDR_W'(w)) begin
                rd_d = shadow_pad[w*SB_CFG_WORD_W +: SB_CFG_WORD_W];
            end
        end
    end

    // Readback register: one cycle from address to data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign config_rd_data = rd_q;
`endif

    for (genvar s = 0; s < SB_SIDES; s++) begin : g_side
        for (genvar t = 0; t < TRACKS; t++) begin : g_track
            localparam int OUT_IDX = s * TRACKS + t;

            logic [NSRC*WIDTH-1:0] srcs;

            for (genvar k = 0; k < 3; k++) begin : g_src
                localparam int SRC_IDX = sb_src_side(s, k) * TRACKS + sb_src_track(t, s, k, TRACKS);
                assign srcs[k*WIDTH +: WIDTH] = in_wires[SRC_IDX*WIDTH +: WIDTH];
            end
            assign srcs[3*WIDTH +: NUM_PE*WIDTH] = pe_outputs;

            sb_track_mux #(
                .WIDTH (WIDTH),
                .NSRC  (NSRC),
                .SEL_W (SEL_W)
            ) u_mux (
                .clk    (clk),
                .reset  (reset),
                .srcs   (srcs),
                .sel    (active[OUT_IDX*F +: SEL_W]),
                .reg_en (active[OUT_IDX*F + SEL_W]),
                .out    (out_wires[OUT_IDX*WIDTH +: WIDTH])
            );
        end
    end

endmodule

// File: tb/tb_switch_box_param.sv
// Self-checking bench: hand-derived vector table, directed corner sequences and
// a randomized run against a field-level reference model of the default build.
module tb_switch_box_param;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    // Default build: WIDTH=1, TRACKS=4, NUM_PE=1 -> F=3, 2 words, ADDR_W=1.
    logic [15:0] in0;
    logic [0:0]  pe0;
    logic [15:0] out0;
    logic        en0;
    logic [0:0]  addr0;
    logic [31:0] data0;
    logic        commit0;

    // Second build: WIDTH=4, TRACKS=6, NUM_PE=2 -> SEL_W=3, F=4, 3 words, ADDR_W=2.
    logic [95:0] in1;
    logic [7:0]  pe1;
    logic [95:0] out1;
    logic        en1;
    logic [1:0]  addr1;
    logic [31:0] data1;
    logic        commit1;

`ifdef SB_CFG_READBACK_EN
    logic [0:0]  rd_addr0;
    logic [31:0] rd_data0;
    logic [1:0]  rd_addr1;
    logic [31:0] rd_data1;
`endif

    switch_box_param #(
        .WIDTH  (1),
        .TRACKS (4),
        .NUM_PE (1)
    ) dut0 (
        .clk            (clk),
        .reset          (reset),
        .in_wires       (in0),
        .pe_outputs     (pe0),
        .config_en      (en0),
        .config_addr    (addr0),
        .config_data    (data0),
        .config_commit  (commit0),
`ifdef SB_CFG_READBACK_EN
        .config_rd_addr (rd_addr0),
        .config_rd_data (rd_data0),
`endif
        .out_wires      (out0)
    );

    switch_box_param #(
        .WIDTH  (4),
        .TRACKS (6),
        .NUM_PE (2)
    ) dut1 (
        .clk            (clk),
        .reset          (reset),
        .in_wires       (in1),
        .pe_outputs     (pe1),
        .config_en      (en1),
        .config_addr    (addr1),
        .config_data    (data1),
        .config_commit  (commit1),
`ifdef SB_CFG_READBACK_EN
        .config_rd_addr (rd_addr1),
        .config_rd_data (rd_data1),
`endif
        .out_wires      (out1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reset routing: out(s,t) = in((s+1)%4, (t+s)%tracks).
    function automatic logic [95:0] reset_route(input logic [95:0] in, input int tracks,
                                                input int width);
        logic [95:0] r;
        r = '0;
        for (int s = 0; s < 4; s++)
            for (int t = 0; t < tracks; t++)
                for (int b = 0; b < width; b++)
                    r[(s*tracks+t)*width+b] = in[(((s+1)%4)*tracks + (t+s)%tracks)*width+b];
        return r;
    endfunction

    // Reference model of the default build: configuration as a flat bit vector.
    logic [63:0] m_shadow;
    logic [63:0] m_active;
    logic        m_reg [16];

    function automatic logic model_mux(input int o);
        int s, t;
        logic [2:0] f;
        s = o / 4;
        t = o % 4;
        f = m_active[o*3 +: 3];
        if (f[1:0] == 2'd3) return pe0[0];
        return in0[((s + 1 + int'(f[1:0])) % 4) * 4 + (t + s + int'(f[1:0])) % 4];
    endfunction

    function automatic logic [15:0] model_out();
        logic [15:0] r;
        for (int o = 0; o < 16; o++)
            r[o] = m_active[o*3+2] ? m_reg[o] : model_mux(o);
        return r;
    endfunction

    task automatic model_clear();
        m_shadow = '0;
        m_active = '0;
        for (int o = 0; o < 16; o++) m_reg[o] = 1'b0;
    endtask

    // One clock: model advances at the rising edge, returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            for (int o = 0; o < 16; o++) m_reg[o] = model_mux(o);
            if (commit0) m_active = m_shadow;
            if (en0) m_shadow[int'(addr0)*32 +: 32] = data0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        tick();
        reset = 1'b0;
    endtask

    task automatic write0(input logic [0:0] a, input logic [31:0] d);
        en0 = 1'b1; addr0 = a; data0 = d;
        tick();
        en0 = 1'b0;
    endtask

    task automatic commit_0();
        commit0 = 1'b1;
        tick();
        commit0 = 1'b0;
    endtask

    task automatic write1(input logic [1:0] a, input logic [31:0] d);
        en1 = 1'b1; addr1 = a; data1 = d;
        tick();
        en1 = 1'b0;
    endtask

    task automatic commit_1();
        commit1 = 1'b1;
        tick();
        commit1 = 1'b0;
    endtask

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          o;
        bit          is_pe;
        int          side;
        int          track;
        bit          regd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [95:0] exp;
        logic [95:0] tmp;
        logic        v_old;
        logic        v_new;
        logic        prev;

        vecs[0] = '{32'h0000_0003, 32'h0000_0000, 0,  1'b1, 0, 0, 1'b0};
        vecs[1] = '{32'h0000_0002, 32'h0000_0000, 0,  1'b0, 3, 2, 1'b0};
        vecs[2] = '{32'h0000_0008, 32'h0000_0000, 1,  1'b0, 2, 2, 1'b0};
        vecs[3] = '{32'h0000_0028, 32'h0000_0000, 1,  1'b0, 2, 2, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'h0000_0000, 10, 1'b0, 1, 2, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h0000_0001, 10, 1'b0, 3, 0, 1'b1};
        vecs[6] = '{32'h0000_0000, 32'h0000_2000, 15, 1'b0, 1, 3, 1'b0};
        vecs[7] = '{32'h0001_8000, 32'h0000_0000, 5,  1'b1, 0, 0, 1'b0};

        en0 = 1'b0; addr0 = '0; data0 = '0; commit0 = 1'b0;
        en1 = 1'b0; addr1 = '0; data1 = '0; commit1 = 1'b0;
`ifdef SB_CFG_READBACK_EN
        rd_addr0 = '0;
        rd_addr1 = '0;
`endif
        in0 = 16'($urandom); pe0 = 1'($urandom);
        in1 = {$urandom, $urandom, $urandom}; pe1 = 8'($urandom);
        model_clear();

        // Reset routing before any clock edge.
        #1 reset = 1'b1;
        #1;
        exp = reset_route(96'(in0), 4, 1);
        check("reset_route0", 96'(out0), {80'd0, exp[15:0]});
        check("reset_route1", out1, reset_route(in1, 6, 4));
        @(negedge clk);
        reset = 1'b0;

        // Table: program both words, commit, then check one output's source and latency.
        for (int i = 0; i < 8; i++) begin
            write0(1'b0, vecs[i].w0);
            write0(1'b1, vecs[i].w1);
            commit_0();
            in0 = 16'($urandom); pe0 = 1'($urandom);
            v_old = vecs[i].is_pe ? pe0[0] : in0[vecs[i].side*4 + vecs[i].track];
            tick();
            in0 = ~in0; pe0 = ~pe0;
            #1;
            v_new = vecs[i].is_pe ? pe0[0] : in0[vecs[i].side*4 + vecs[i].track];
            check($sformatf("vec%0d", i), 96'(out0[vecs[i].o]), 96'(vecs[i].regd ? v_old : v_new));
        end

        // Shadow write without commit leaves routing alone; commit switches immediately.
        do_reset();
        write0(1'b0, 32'h3);
        in0 = 16'($urandom); #1;
        check("nocommit", 96'(out0[0]), 96'(in0[4]));
        commit_0();
        pe0 = 1'b1; #1;
        check("commit_pe_hi", 96'(out0[0]), 96'(1'b1));
        pe0 = 1'b0; #1;
        check("commit_pe_lo", 96'(out0[0]), 96'(1'b0));

        // Registered path tracks in(2,2) one cycle late, then goes combinational again.
        write0(1'b0, 32'h28);
        commit_0();
        for (int c = 0; c < 4; c++) begin
            in0 = 16'($urandom);
            prev = in0[10];
            tick();
            in0 = ~in0; #1;
            check("reg_delay", 96'(out0[1]), 96'(prev));
        end
        write0(1'b0, 32'h08);
        commit_0();
        in0 = 16'($urandom); #1;
        check("back_comb_a", 96'(out0[1]), 96'(in0[10]));
        in0 = ~in0; #1;
        check("back_comb_b", 96'(out0[1]), 96'(in0[10]));

        // Same-cycle write and commit: active keeps pre-write shadow until next commit.
        do_reset();
        en0 = 1'b1; addr0 = 1'b1; data0 = 32'h0000_FFFF; commit0 = 1'b1;
        tick();
        en0 = 1'b0; commit0 = 1'b0;
        in0 = 16'($urandom); #1;
        exp = reset_route(96'(in0), 4, 1);
        check("wr_commit_same", 96'(out0), {80'd0, exp[15:0]});
        commit_0();
        pe0 = 1'b1;
        tick();
        pe0 = 1'b0; #1;
        check("second_commit", 96'(out0[15:11]), 96'(5'b11111));

        // Out-of-range address on the 3-word build is ignored.
        do_reset();
        write1(2'd3, 32'hFFFF_FFFF);
        commit_1();
        in1 = {$urandom, $urandom, $urandom}; #1;
        check("oor_write", out1, reset_route(in1, 6, 4));

        // Select code at or above NSRC drives zero.
        write1(2'd0, 32'h5);
        commit_1();
        in1 = '1; pe1 = '1; #1;
        check("sel_zero", 96'(out1[3:0]), 96'(4'h0));

        // Asynchronous reset between edges drops registered outputs to k=0 routing.
        write1(2'd0, 32'h9);
        commit_1();
        in1 = {$urandom, $urandom, $urandom};
        tick();
        in1 = ~in1;
        #2 reset = 1'b1;
        #1;
        check("async_reset", out1, reset_route(in1, 6, 4));
        model_clear();
        @(negedge clk);
        reset = 1'b0;

`ifdef SB_CFG_READBACK_EN
        write0(1'b0, 32'h1234);
        write0(1'b1, 32'hFFFF_FFFF);
        rd_addr0 = 1'b0;
        tick(); #1;
        check("rd_word0", 96'(rd_data0), 96'(32'h1234));
        rd_addr0 = 1'b1;
        tick(); #1;
        check("rd_word1_pad", 96'(rd_data0), 96'(32'h0000_FFFF));
        write1(2'd2, 32'hABCD_0123);
        rd_addr1 = 2'd2;
        tick(); #1;
        check("rd1_word2", 96'(rd_data1), 96'(32'hABCD_0123));
        rd_addr1 = 2'd3;
        tick(); #1;
        check("rd1_oor", 96'(rd_data1), 96'(32'h0));
`endif

        // Randomized run against the reference model.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            en0     = 1'($urandom);
            addr0   = 1'($urandom);
            data0   = $urandom;
            commit0 = ($urandom_range(3) == 0);
            in0     = 16'($urandom);
            pe0     = 1'($urandom);
            #1;
            check($sformatf("rand%0d", c), 96'(out0), 96'(model_out()));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
